// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges PS/2 keys and MiSTer joystick words into registered
// per-player controls with rotation, opposing-direction cleanup, coin shaping and autofire.
module arcade_input_mapper #(
  parameter int unsigned PLAYERS         = 2,
  parameter logic [15:0] COIN_PULSE      = 16'd20000,
  parameter int unsigned AUTOFIRE_FRAMES = 4,
  parameter bit          SOCD_NEUTRAL    = 1'b1
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joy_in,
  input  logic [1:0]             rotate,
  input  logic                   frame_tick,
  input  logic [PLAYERS-1:0]     autofire_en,
  output logic [4*PLAYERS-1:0]   dir_out,
  output logic [2*PLAYERS-1:0]   fire_out,
  output logic [PLAYERS-1:0]     start_out,
  output logic [PLAYERS-1:0]     coin_out
);

  localparam int unsigned CNT_W = $clog2(COIN_PULSE) + 1;
  localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_PULSE - 16'd1);
  localparam logic [3:0] AF_LAST = 4'(AUTOFIRE_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_LOCK} coin_state_e;

  // One bit per physical key so that two keys sharing a function release independently.
  logic                          old_toggle_q, old_toggle_d;
  logic [9:0]                    p0_key_q, p0_key_d;
  logic [8:0]                    p1_key_q, p1_key_d;
  logic [PLAYERS-1:0][7:0]       key_bits;
  logic [PLAYERS-1:0][7:0]       raw_q, raw_d;
  logic [PLAYERS-1:0]            coin_prev_q, coin_prev_d;
  coin_state_e                   coin_st_q [PLAYERS];
  coin_state_e                   coin_st_d [PLAYERS];
  logic [CNT_W-1:0]              coin_cnt_q [PLAYERS];
  logic [CNT_W-1:0]              coin_cnt_d [PLAYERS];
  logic [PLAYERS-1:0]            af_phase_q, af_phase_d;
  logic [3:0]                    af_cnt_q [PLAYERS];
  logic [3:0]                    af_cnt_d [PLAYERS];
  logic [4*PLAYERS-1:0]          dir_q, dir_d;
  logic [2*PLAYERS-1:0]          fire_q, fire_d;
  logic [PLAYERS-1:0]            start_q, start_d;
  logic [PLAYERS-1:0]            coin_q, coin_d;
  logic                          unused_joy;

  always_comb begin
    old_toggle_d = old_toggle_q;
    p0_key_d     = p0_key_q;
    p1_key_d     = p1_key_q;
    if (ps2_key[10] != old_toggle_q) begin
      old_toggle_d = ps2_key[10];
      case (ps2_key[8:0])
        9'h175: p0_key_d[0] = ps2_key[9];
        9'h172: p0_key_d[1] = ps2_key[9];
        9'h16B: p0_key_d[2] = ps2_key[9];
        9'h174: p0_key_d[3] = ps2_key[9];
        9'h029: p0_key_d[4] = ps2_key[9];
        9'h014: p0_key_d[5] = ps2_key[9];
        9'h011: p0_key_d[6] = ps2_key[9];
        9'h016: p0_key_d[7] = ps2_key[9];
        9'h005: p0_key_d[8] = ps2_key[9];
        9'h02E: p0_key_d[9] = ps2_key[9];
        9'h02D: p1_key_d[0] = ps2_key[9];
        9'h02B: p1_key_d[1] = ps2_key[9];
        9'h023: p1_key_d[2] = ps2_key[9];
        9'h034: p1_key_d[3] = ps2_key[9];
        9'h01C: p1_key_d[4] = ps2_key[9];
        9'h01B: p1_key_d[5] = ps2_key[9];
        9'h01E: p1_key_d[6] = ps2_key[9];
        9'h006: p1_key_d[7] = ps2_key[9];
        9'h036: p1_key_d[8] = ps2_key[9];
        default: ;
      endcase
    end
  end

  // Key bits packed in joystick order {coin,start,fireB,fireA,up,down,left,right}.
  always_comb begin
    key_bits   = '0;
    unused_joy = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      unused_joy = unused_joy ^ (^joy_in[16*p+8 +: 8]);
      if (p == 0)
        key_bits[p] = {p0_key_q[9], p0_key_q[7] | p0_key_q[8], p0_key_q[6],
                       p0_key_q[4] | p0_key_q[5], p0_key_q[0], p0_key_q[1],
                       p0_key_q[2], p0_key_q[3]};
      else if (p == 1)
        key_bits[p] = {p1_key_q[8], p1_key_q[6] | p1_key_q[7], p1_key_q[5],
                       p1_key_q[4], p1_key_q[0], p1_key_q[1], p1_key_q[2], p1_key_q[3]};
    end
  end

  always_comb begin
    logic up, dn, lf, rt;
    up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
    raw_d       = raw_q;
    coin_prev_d = coin_prev_q;
    coin_st_d   = coin_st_q;
    coin_cnt_d  = coin_cnt_q;
    af_phase_d  = af_phase_q;
    af_cnt_d    = af_cnt_q;
    dir_d       = dir_q;
    fire_d      = fire_q;
    start_d     = start_q;
    coin_d      = coin_q;
    for (int p = 0; p < PLAYERS; p++) begin
      raw_d[p] = joy_in[16*p +: 8] | key_bits[p];

      case (rotate)
        2'd1:    begin up = raw_q[p][1]; dn = raw_q[p][0]; lf = raw_q[p][2]; rt = raw_q[p][3]; end
        2'd2:    begin up = raw_q[p][2]; dn = raw_q[p][3]; lf = raw_q[p][0]; rt = raw_q[p][1]; end
        2'd3:    begin up = raw_q[p][0]; dn = raw_q[p][1]; lf = raw_q[p][3]; rt = raw_q[p][2]; end
        default: begin up = raw_q[p][3]; dn = raw_q[p][2]; lf = raw_q[p][1]; rt = raw_q[p][0]; end
      endcase
      if (SOCD_NEUTRAL && up && dn) begin up = 1'b0; dn = 1'b0; end
      if (SOCD_NEUTRAL && lf && rt) begin lf = 1'b0; rt = 1'b0; end
      dir_d[4*p +: 4] = {up, dn, lf, rt};
      fire_d[2*p+1]   = raw_q[p][5];
      start_d[p]      = raw_q[p][6];

      // Phase restarts high whenever fireA is released so a fresh press fires at once.
      if (!autofire_en[p] || !raw_q[p][4]) begin
        fire_d[2*p]   = raw_q[p][4] & ~autofire_en[p];
        af_phase_d[p] = 1'b1;
        af_cnt_d[p]   = '0;
      end else begin
        fire_d[2*p] = af_phase_q[p];
        if (frame_tick) begin
          if (af_cnt_q[p] == AF_LAST) begin
            af_phase_d[p] = ~af_phase_q[p];
            af_cnt_d[p]   = '0;
          end else begin
            af_cnt_d[p] = af_cnt_q[p] + 4'd1;
          end
        end
      end

      coin_prev_d[p] = raw_q[p][7];
      case (coin_st_q[p])
        ST_IDLE: if (raw_q[p][7] && !coin_prev_q[p]) begin
          coin_st_d[p]  = ST_PULSE;
          coin_cnt_d[p] = COIN_LOAD;
        end
        ST_PULSE: if (coin_cnt_q[p] == '0) coin_st_d[p] = ST_LOCK;
                  else coin_cnt_d[p] = coin_cnt_q[p] - 1'b1;
        ST_LOCK: if (!raw_q[p][7]) coin_st_d[p] = ST_IDLE;
        default: coin_st_d[p] = ST_IDLE;
      endcase
      coin_d[p] = (coin_st_d[p] == ST_PULSE);
    end
  end

  // Raw coin and its history reset to 1 so a coin held through reset cannot pulse.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_toggle_q <= ps2_key[10];
      p0_key_q     <= '0;
      p1_key_q     <= '0;
      coin_prev_q  <= '1;
      af_phase_q   <= '1;
      dir_q        <= '0;
      fire_q       <= '0;
      start_q      <= '0;
      coin_q       <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        raw_q[p]      <= 8'h80;
        coin_st_q[p]  <= ST_IDLE;
        coin_cnt_q[p] <= '0;
        af_cnt_q[p]   <= '0;
      end
    end else begin
      old_toggle_q <= old_toggle_d;
      p0_key_q     <= p0_key_d;
      p1_key_q     <= p1_key_d;
      raw_q        <= raw_d;
      coin_prev_q  <= coin_prev_d;
      coin_st_q    <= coin_st_d;
      coin_cnt_q   <= coin_cnt_d;
      af_phase_q   <= af_phase_d;
      af_cnt_q     <= af_cnt_d;
      dir_q        <= dir_d;
      fire_q       <= fire_d;
      start_q      <= start_d;
      coin_q       <= coin_d;
    end
  end

  assign dir_out   = dir_q;
  assign fire_out  = fire_q;
  assign start_out = start_q;
  assign coin_out  = coin_q;

endmodule
